// File: rtl/serialize_pkg.sv
// serialize_pkg: shared types and constants for the serialize_tx transmitter.
// Optional feature macro: SERIALIZE_TX_PARITY_EN (adds an even-parity bit per frame).
package serialize_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      START  = 2'd1,
      DATA   = 2'd2,
      PARITY = 2'd3
   } tx_state_t;

   localparam logic START_BIT  = 1'b1;
   localparam logic IDLE_LEVEL = 1'b0;

   // Number of line cycles one frame occupies: start bit, data bits, optional parity
   function automatic int unsigned frame_len(input int unsigned width, input bit parity);
      return width + 32'd1 + (parity ? 32'd1 : 32'd0);
   endfunction

endpackage

// File: rtl/piso_shift.sv
// piso_shift: parallel-in serial-out shift register, MSB presented first.
module piso_shift #(
   parameter int unsigned DATA_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_load,
   input  logic                  i_shift,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  o_msb
);

   logic [DATA_WIDTH-1:0] r_sh;

   // Load has priority over shift; shift moves the next bit into the MSB slot
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sh <= '0;
      end else if (i_load) begin
         r_sh <= i_data;
      end else if (i_shift) begin
         r_sh <= {r_sh[DATA_WIDTH-2:0], 1'b0};
      end
   end

   assign o_msb = r_sh[DATA_WIDTH-1];

endmodule

// File: rtl/serialize_tx.sv
// serialize_tx: valid/ready word input, one-entry buffer, framed serial output
// (start bit then data MSB first). Define SERIALIZE_TX_PARITY_EN to append an
// even-parity bit to every frame.
import serialize_pkg::*;

module serialize_tx #(
   parameter int unsigned DATA_WIDTH = 4
) (
   input  logic                  fastClk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] dataIn,
   input  logic                  valid,
   output logic                  ready,
   output logic                  dataOut,
   output logic                  busy
);

   localparam int unsigned CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

   tx_state_t             r_state;
   tx_state_t             w_state_nxt;
   logic [DATA_WIDTH-1:0] r_buf;
   logic                  r_buf_full;
   logic [CNT_W-1:0]      r_bit_cnt;
   logic [CNT_W-1:0]      w_bit_cnt_nxt;
   logic                  r_dout;
   logic                  w_dout_nxt;
   logic                  r_busy;
   logic                  w_load;
   logic                  w_shift;
   logic                  w_msb;
   logic                  w_accept;
`ifdef SERIALIZE_TX_PARITY_EN
   logic                  r_par;
`endif

   assign w_accept = valid && !r_buf_full;
   assign ready    = !r_buf_full;
   assign dataOut  = r_dout;
   assign busy     = r_busy;

   piso_shift #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_piso (
      .clk    (fastClk),
      .rst    (reset),
      .i_load (w_load),
      .i_shift(w_shift),
      .i_data (r_buf),
      .o_msb  (w_msb)
   );

   // One-entry input buffer: filled on handshake, drained when a frame starts
   always_ff @(posedge fastClk or posedge reset) begin
      if (reset) begin
         r_buf      <= '0;
         r_buf_full <= 1'b0;
      end else if (w_load) begin
         r_buf_full <= 1'b0;
      end else if (w_accept) begin
         r_buf      <= dataIn;
         r_buf_full <= 1'b1;
      end
   end

`ifdef SERIALIZE_TX_PARITY_EN
   // Even-parity accumulator over the data bits as they go onto the line
   always_ff @(posedge fastClk or posedge reset) begin
      if (reset) begin
         r_par <= 1'b0;
      end else if (w_load) begin
         r_par <= 1'b0;
      end else if (w_shift) begin
         r_par <= r_par ^ w_msb;
      end
   end
`endif

   // FSM state and registered line outputs
   always_ff @(posedge fastClk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_bit_cnt <= '0;
         r_dout    <= IDLE_LEVEL;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_dout    <= w_dout_nxt;
         r_busy    <= (w_state_nxt != IDLE);
      end
   end

   // Next-state, shifter control and next line level
   always_comb begin
      w_state_nxt   = r_state;
      w_bit_cnt_nxt = r_bit_cnt;
      w_dout_nxt    = r_dout;
      w_load        = 1'b0;
      w_shift       = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_buf_full) begin
               w_state_nxt = START;
               w_load      = 1'b1;
               w_dout_nxt  = START_BIT;
            end
         end
         START: begin
            w_state_nxt   = DATA;
            w_dout_nxt    = w_msb;
            w_shift       = 1'b1;
            w_bit_cnt_nxt = CNT_W'(DATA_WIDTH - 1);
         end
         DATA: begin
            if (r_bit_cnt != '0) begin
               w_dout_nxt    = w_msb;
               w_shift       = 1'b1;
               w_bit_cnt_nxt = r_bit_cnt - CNT_W'(1);
`ifdef SERIALIZE_TX_PARITY_EN
            end else begin
               w_state_nxt = PARITY;
               w_dout_nxt  = r_par;
            end
`else
            end else if (r_buf_full) begin
               w_state_nxt = START;
               w_load      = 1'b1;
               w_dout_nxt  = START_BIT;
            end else begin
               w_state_nxt = IDLE;
               w_dout_nxt  = IDLE_LEVEL;
            end
`endif
         end
`ifdef SERIALIZE_TX_PARITY_EN
         PARITY: begin
            if (r_buf_full) begin
               w_state_nxt = START;
               w_load      = 1'b1;
               w_dout_nxt  = START_BIT;
            end else begin
               w_state_nxt = IDLE;
               w_dout_nxt  = IDLE_LEVEL;
            end
         end
`endif
         default: begin
            w_state_nxt = IDLE;
            w_dout_nxt  = IDLE_LEVEL;
         end
      endcase
   end

endmodule

// File: tb/tb_serialize_tx.sv
// tb_serialize_tx: directed and random stimulus for serialize_tx, checked every
// cycle against a frame-schedule reference model (accept time -> frame start time).
module tb_serialize_tx;

   localparam int W = 4;
`ifdef SERIALIZE_TX_PARITY_EN
   localparam int PAR = 1;
   localparam logic [15:0] EXP_1011 = 16'b1101110;
   localparam logic [15:0] EXP_0110 = 16'b1011000;
   localparam logic [15:0] EXP_0000 = 16'b1000000;
   localparam logic [15:0] EXP_B2B  = 16'b1010101110000;
`else
   localparam int PAR = 0;
   localparam logic [15:0] EXP_1011 = 16'b110110;
   localparam logic [15:0] EXP_0110 = 16'b101100;
   localparam logic [15:0] EXP_0000 = 16'b100000;
   localparam logic [15:0] EXP_B2B  = 16'b10101111000;
`endif
   localparam int FL = W + 1 + PAR;

   logic         fastClk;
   logic         reset;
   logic [W-1:0] dataIn;
   logic         valid;
   logic         ready;
   logic         dataOut;
   logic         busy;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   logic m_ready = 1'b1;

   typedef struct {
      int           a;
      int           s;
      logic [W-1:0] w;
   } frm_t;
   frm_t fq[$];

   serialize_tx #(.DATA_WIDTH(W)) dut (
      .fastClk(fastClk),
      .reset  (reset),
      .dataIn (dataIn),
      .valid  (valid),
      .ready  (ready),
      .dataOut(dataOut),
      .busy   (busy)
   );

   initial begin
      fastClk = 1'b0;
      forever #5 fastClk = ~fastClk;
   end

   // Expected {ready, busy, dataOut} after edge e, from the frame schedule
   function automatic logic [2:0] model(input int e);
      logic r;
      logic bz;
      logic d;
      int   o;
      r  = 1'b1;
      bz = 1'b0;
      d  = 1'b0;
      foreach (fq[i]) begin
         if (fq[i].a <= e && e < fq[i].s) r = 1'b0;
         if (fq[i].s <= e && e < fq[i].s + FL) begin
            bz = 1'b1;
            o  = e - fq[i].s;
            if (o == 0)      d = 1'b1;
            else if (o <= W) d = fq[i].w[W-o];
            else             d = ^fq[i].w;
         end
      end
      return {r, bz, d};
   endfunction

   task automatic check(input string tag, input logic act, input logic exp);
      total++;
      assert (act === exp) else begin
         bad++;
         $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, act, exp);
      end
   endtask

   // One clock: drive inputs, let the edge happen, update model, check outputs
   task automatic step(input logic v, input logic [W-1:0] d);
      logic [2:0] m;
      frm_t       f;
      valid  = v;
      dataIn = d;
      @(posedge fastClk);
      if (v && m_ready && !reset) begin
         f.a = cyc + 1;
         f.s = cyc + 2;
         if (fq.size() > 0 && fq[fq.size()-1].s + FL > f.s) f.s = fq[fq.size()-1].s + FL;
         f.w = d;
         fq.push_back(f);
      end
      cyc++;
      @(negedge fastClk);
      m = model(cyc);
      check("ready", ready, m[2]);
      check("busy", busy, m[1]);
      check("dout", dataOut, m[0]);
      m_ready = m[2];
   endtask

   // Send one word from idle and compare the following line samples to a constant
   task automatic send_collect(input logic [W-1:0] w, input logic [15:0] exp, input string tag);
      logic [15:0] sv;
      sv = '0;
      step(1'b1, w);
      for (int i = 0; i < FL + 1; i++) begin
         step(1'b0, '0);
         sv = {sv[14:0], dataOut};
      end
      total++;
      assert (sv === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, sv, exp);
      end
   endtask

   initial begin
      logic [15:0] sv;
      logic        v;
      logic        hold;
      logic        acc;
      logic [W-1:0] d;

      reset  = 1'b1;
      valid  = 1'b0;
      dataIn = '0;
      @(negedge fastClk);
      @(negedge fastClk);
      check("rst_ready", ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_dout", dataOut, 1'b0);
      reset = 1'b0;
      step(1'b0, '0);

      // Single frames from idle
      send_collect(4'b1011, EXP_1011, "frame_1011");
      send_collect(4'b0110, EXP_0110, "frame_0110");
      send_collect(4'h0, EXP_0000, "frame_0000");

      // Back-to-back: second word accepted while the first is on the line
      sv = '0;
      step(1'b1, 4'h5);
      for (int i = 0; i < 2 * FL + 1; i++) begin
         step(i == 1, 4'hC);
         sv = {sv[14:0], dataOut};
      end
      total++;
      assert (sv === EXP_B2B) else begin
         bad++;
         $error("FAIL b2b_stream observed=%b expected=%b", sv, EXP_B2B);
      end

      // valid held while buffer full: refused, then taken the cycle after drain
      step(1'b1, 4'hA);
      check("held_ready_low", ready, 1'b0);
      step(1'b1, 4'h3);
      check("held_ready_back", ready, 1'b1);
      step(1'b1, 4'h3);
      for (int i = 0; i < 2 * FL + 2; i++) step(1'b0, '0);

      // Asynchronous reset in the middle of the data bits of 4'hA
      step(1'b1, 4'hA);
      step(1'b0, '0);
      step(1'b0, '0);
      step(1'b0, '0);
      check("pre_rst_busy", busy, 1'b1);
      reset = 1'b1;
      #1;
      check("arst_dout", dataOut, 1'b0);
      check("arst_busy", busy, 1'b0);
      check("arst_ready", ready, 1'b1);
      fq.delete();
      m_ready = 1'b1;
      step(1'b0, '0);
      step(1'b0, '0);
      reset = 1'b0;
      step(1'b0, '0);
      send_collect(4'b0110, EXP_0110, "after_rst_0110");

      // Random producer traffic, sometimes holding valid until taken
      hold = 1'b0;
      v    = 1'b0;
      d    = '0;
      for (int n = 0; n < 400; n++) begin
         if (!hold) begin
            v = ($urandom_range(0, 2) != 0);
            d = W'($urandom);
         end
         acc = v && m_ready;
         step(v, d);
         hold = v && !acc && ($urandom_range(0, 3) != 0);
      end
      for (int i = 0; i < 2 * FL + 2; i++) step(1'b0, '0);
      check("end_busy", busy, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serialize_tx.md
# serialize_tx

- Parallel-to-serial transmitter on a single `fastClk` domain.
- Accepts `DATA_WIDTH`-bit words through a valid/ready handshake and holds one word in a one-entry buffer.
- Emits each word as a framed serial bit stream, MSB first, behind a start bit.
- It is the sending end of the serial link whose receiving end is the `shift_reg`/sync/decode chain.

## Interface

- `DATA_WIDTH`, default 4: width of the parallel word and number of serial data bits per frame.
- `fastClk` input, 1 bit: sole clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-high; clears all state.
- `dataIn` input, `DATA_WIDTH` bits: parallel word, sampled when `valid && ready`.
- `valid` input, 1 bit: producer offers `dataIn`.
- `ready` output, 1 bit: `ready = !bufFull`; combinational from a register only, no path from `valid`.
- `dataOut` output, 1 bit: registered serial line; idle level 0.
- `busy` output, 1 bit: registered; 1 while a frame is on the line (state != IDLE).

## Operation

- FSM states: IDLE, START, DATA, and PARITY (PARITY exists only with the macro).
- Handshake:
  - A transfer occurs at a rising edge where `valid && ready`. The word is written to the buffer and `bufFull` is set.
  - `valid` with `ready=0` is ignored; the producer holds.
- Transitions:
  - IDLE → START: when `bufFull`. Buffer moves into the shift register, `bufFull` clears, `dataOut=1` (start bit).
  - START → DATA: `dataOut` = shifter MSB, `bitCnt=DATA_WIDTH-1`.
  - DATA, `bitCnt>0`: shift left, `dataOut` = next bit, `bitCnt` decrements.
  - DATA, `bitCnt==0`:
    - With parity: go to PARITY.
    - Without parity, `bufFull`: go to START, reloading the shifter. No idle gap between frames.
    - Without parity, buffer empty: go to IDLE, `dataOut=0`.
  - PARITY → START or IDLE, using the same `bufFull` rule.
- Buffer load during a frame is allowed. The buffered word is untouched until the frame boundary.
- Same-edge buffer drain and `ready` reassertion:
  - The drain edge clears `bufFull`, so `ready` rises in the following cycle.
  - There is no same-cycle pass-through.
- `bitCnt` width is `$clog2(DATA_WIDTH)`, minimum 1. `DATA_WIDTH >= 2` is required.
- Reset mid-frame:
  - Immediate and asynchronous: `dataOut=0`, `busy=0`, `bufFull=0` (so `ready=1`), state IDLE.
  - A partial frame is abandoned, not completed.

## Timing

- Reset values: `dataOut=0`, `busy=0`, `ready=1`.
- Word accepted at edge k with FSM in IDLE:
  - Edge k+1: start bit on `dataOut`, `busy=1`.
  - Edges k+2 … k+1+`DATA_WIDTH`: data bits, MSB first.
- Frame length is `DATA_WIDTH+1` cycles, or `DATA_WIDTH+2` with parity.
- Back-to-back throughput is one word per frame length, with no gap, provided the buffer is refilled before the last bit of the current frame.
- `ready` falls the cycle after acceptance and rises the cycle after the buffer drains into the shifter.
- `busy` falls at the same edge that `dataOut` returns to idle.

## Configuration

- `SERIALIZE_TX_PARITY_EN`, defined:
  - A PARITY state follows the last data bit.
  - `dataOut` = even parity, i.e. XOR of all `DATA_WIDTH` data bits of that frame.
- Undefined:
  - No PARITY state exists.
  - The frame is start bit plus data only.

## Structure

- Package `serialize_pkg` holds:
  - `tx_state_t` enum: IDLE, START, DATA, PARITY.
  - `START_BIT = 1'b1` and `IDLE_LEVEL = 1'b0`.
  - Function `frame_len(width, parity)`.
- One sub-module, `piso_shift` (parallel-in serial-out, `DATA_WIDTH`):
  - Ports: load, shift, parallel in, MSB out.
  - Instantiated once.
- The FSM, buffer and parity accumulator live in `serialize_tx`.

## Test plan

- Reset asserted mid-DATA of word 4'hA → `dataOut=0`, `busy=0`, `ready=1` asynchronously; first frame after release is the next accepted word only.
- Idle, send 4'b1011 → `dataOut` over edges k+1..k+5 = 1,1,0,1,1, then 0 with `busy=0`.
- Words 4'h5 then 4'hC, second sent during frame 1 → stream 1,0,1,0,1,1,1,1,0,0 with no idle cycle; `ready` low from acceptance to reload.
- `valid` held with buffer full → second word not taken (`ready=0`); taken the cycle after drain, and the data matches.
- With `SERIALIZE_TX_PARITY_EN`, send 4'b1011 → 1,1,0,1,1,1 (parity 1); send 4'b0110 → 1,0,1,1,0,0.
- Word 4'h0 → 1,0,0,0,0; start bit distinguishable from the idle line.
